// File: rtl/keystream_gen_if.sv
// Keystream bus: key loading inputs, keystream handshake and status.
// master = key/consumer side, slave = keystream_gen.
interface keystream_gen_if;
  logic        key_valid;
  logic [7:0]  key_byte;
  logic        ks_ready;
  logic [7:0]  ks_byte;
  logic        ks_valid;
  logic        busy;
  logic [15:0] byte_count;

  modport master (
    output key_valid, key_byte, ks_ready,
    input  ks_byte, ks_valid, busy, byte_count
  );

  modport slave (
    input  key_valid, key_byte, ks_ready,
    output ks_byte, ks_valid, busy, byte_count
  );
endinterface

// File: rtl/keystream_gen.sv
// keystream_gen: byte-serial key load into a Galois LFSR, optional warm-up,
// then one keystream byte per ks_valid/ks_ready handshake.
// Optional macro KS_NONLINEAR_FILTER_EN: output byte passes through a small
// nonlinear filter instead of the raw low byte of the LFSR.
//
// state  | meaning
// IDLE   | no key loaded since reset
// LOAD   | collecting key bytes (load_cnt counts bytes taken)
// WARMUP | discarding WARMUP_STEPS byte-steps
// RUN    | keystream byte valid, advances on handshake
module keystream_gen #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] TAPS         = 32'h8020_0003,
  parameter int               WARMUP_STEPS = 16,
  parameter logic [WIDTH-1:0] ZERO_SEED    = 32'hACE1_5EED
) (
  input logic           clk,
  input logic           rst_n,
  input logic           ena,
  keystream_gen_if.slave bus
);

  localparam int NBYTES = WIDTH / 8;
  localparam int LW     = $clog2(NBYTES + 1);
  localparam int WW     = (WARMUP_STEPS > 0) ? $clog2(WARMUP_STEPS + 1) : 1;
  localparam logic [LW-1:0] LOAD_LAST = LW'(NBYTES);
  localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_STEPS);

  typedef enum logic [1:0] {IDLE, LOAD, WARMUP, RUN} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] lfsr, lfsr_d;
  logic [LW-1:0]    load_cnt, load_cnt_d, load_next;
  logic [WW-1:0]    warm_cnt, warm_cnt_d, warm_next;
  logic             ks_valid_q, ks_valid_d;
  logic [7:0]       ks_byte_q, ks_next;
  logic [15:0]      count_q, count_d;
  logic [WIDTH-1:0] shifted;

  // Eight Galois shifts in one clock.
  function automatic logic [WIDTH-1:0] byte_step(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] t;
    t = s;
    for (int i = 0; i < 8; i++) begin
      t = t[0] ? ((t >> 1) ^ TAPS) : (t >> 1);
    end
    return t;
  endfunction

  assign shifted   = {lfsr[WIDTH-9:0], bus.key_byte};
  assign load_next = load_cnt + LW'(1);
  assign warm_next = warm_cnt + WW'(1);

  // Next-state and datapath decode; a key byte always wins over a handshake.
  always_comb begin
    state_d    = state;
    lfsr_d     = lfsr;
    load_cnt_d = load_cnt;
    warm_cnt_d = warm_cnt;
    ks_valid_d = ks_valid_q;
    count_d    = count_q;
    if (bus.key_valid) begin
      lfsr_d     = shifted;
      state_d    = LOAD;
      ks_valid_d = 1'b0;
      if (state == LOAD) begin
        load_cnt_d = load_next;
        if (load_next == LOAD_LAST) begin
          if (shifted == '0) lfsr_d = ZERO_SEED;
          count_d    = '0;
          warm_cnt_d = '0;
          if (WARMUP_STEPS == 0) begin
            state_d    = RUN;
            ks_valid_d = 1'b1;
          end else begin
            state_d = WARMUP;
          end
        end
      end else begin
        load_cnt_d = LW'(1);
      end
    end else begin
      case (state)
        WARMUP: begin
          lfsr_d     = byte_step(lfsr);
          warm_cnt_d = warm_next;
          if (warm_next == WARM_LAST) begin
            state_d    = RUN;
            ks_valid_d = 1'b1;
          end
        end
        RUN: begin
          if (ks_valid_q && bus.ks_ready) begin
            lfsr_d = byte_step(lfsr);
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef KS_NONLINEAR_FILTER_EN
  assign ks_next = lfsr_d[7:0] ^ (lfsr_d[15:8] & lfsr_d[23:16]) ^ lfsr_d[WIDTH-1:WIDTH-8];
`else
  assign ks_next = lfsr_d[7:0];
`endif

  // State and datapath registers, all held while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lfsr       <= '0;
      load_cnt   <= '0;
      warm_cnt   <= '0;
      ks_valid_q <= 1'b0;
      ks_byte_q  <= '0;
      count_q    <= '0;
    end else if (ena) begin
      state      <= state_d;
      lfsr       <= lfsr_d;
      load_cnt   <= load_cnt_d;
      warm_cnt   <= warm_cnt_d;
      ks_valid_q <= ks_valid_d;
      ks_byte_q  <= ks_next;
      count_q    <= count_d;
    end
  end

  assign bus.ks_valid   = ks_valid_q;
  assign bus.ks_byte    = ks_byte_q;
  assign bus.byte_count = count_q;
  assign bus.busy       = (state == LOAD) || (state == WARMUP);

endmodule

// File: tb/tb_keystream_gen.sv
// Bench for keystream_gen: two instances (no warm-up and default warm-up)
// driven by identical stimulus; expected bytes are queued per instance and
// popped by monitors on each handshake.
module tb_keystream_gen;
  localparam logic [31:0] TAPS = 32'h8020_0003;
  localparam logic [31:0] ZS   = 32'hACE1_5EED;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       key_valid = 1'b0;
  logic       ks_ready = 1'b0;
  logic [7:0] key_byte = 8'h00;

  int tests = 0;
  int fails = 0;
  int prev_cnt = 0;

  typedef struct packed {
    logic [7:0]  ks;
    logic [15:0] cnt;
  } exp_t;
  exp_t q0[$];
  exp_t q16[$];

  always #5 clk = ~clk;

  keystream_gen_if bus0();
  keystream_gen_if bus16();

  assign bus0.key_valid  = key_valid;
  assign bus0.key_byte   = key_byte;
  assign bus0.ks_ready   = ks_ready;
  assign bus16.key_valid = key_valid;
  assign bus16.key_byte  = key_byte;
  assign bus16.ks_ready  = ks_ready;

  keystream_gen #(.WARMUP_STEPS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus0.slave)
  );
  keystream_gen dut16 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus16.slave)
  );

  function automatic logic [31:0] gal_step(input logic [31:0] v);
    logic [31:0] s;
    s = v;
    for (int b = 0; b < 8; b++) s = (s >> 1) ^ (s[0] ? TAPS : 32'h0);
    return s;
  endfunction

  function automatic logic [7:0] model_out(input logic [31:0] s);
`ifdef KS_NONLINEAR_FILTER_EN
    return s[7:0] ^ (s[15:8] & s[23:16]) ^ s[31:24];
`else
    return s[7:0];
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected(input logic [31:0] key, input int m);
    logic [31:0] s;
    exp_t e;
    for (int w = 0; w < 2; w++) begin
      s = (key == 32'h0) ? ZS : key;
      if (w == 1) repeat (16) s = gal_step(s);
      for (int k = 0; k < m; k++) begin
        e.ks  = model_out(s);
        e.cnt = 16'(k);
        if (w == 0) q0.push_back(e);
        else q16.push_back(e);
        s = gal_step(s);
      end
    end
  endtask

  task automatic check_hs(input int w, input logic [7:0] ks, input logic [15:0] cnt);
    exp_t e;
    if (w == 0) begin
      if (q0.size() == 0) begin
        tests++; fails++;
        $display("FAIL hs_underflow0: got handshake byte %0h expected none", ks);
        return;
      end
      e = q0.pop_front();
      chk("ks_byte0", 32'(ks), 32'(e.ks));
      chk("hs_count0", 32'(cnt), 32'(e.cnt));
    end else begin
      if (q16.size() == 0) begin
        tests++; fails++;
        $display("FAIL hs_underflow16: got handshake byte %0h expected none", ks);
        return;
      end
      e = q16.pop_front();
      chk("ks_byte16", 32'(ks), 32'(e.ks));
      chk("hs_count16", 32'(cnt), 32'(e.cnt));
    end
  endtask

  logic       hold0 = 1'b0, hold16 = 1'b0;
  logic [7:0] last0 = 8'h00, last16 = 8'h00;

  // Monitor for the no-warm-up instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold0) chk("hold0", 32'(bus0.ks_byte), 32'(last0));
      if (ena && bus0.ks_valid && ks_ready && !key_valid) check_hs(0, bus0.ks_byte, bus0.byte_count);
      hold0 = bus0.ks_valid && !(ena && (ks_ready || key_valid));
      last0 = bus0.ks_byte;
    end else hold0 = 1'b0;
  end

  // Monitor for the default-warm-up instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold16) chk("hold16", 32'(bus16.ks_byte), 32'(last16));
      if (ena && bus16.ks_valid && ks_ready && !key_valid) check_hs(1, bus16.ks_byte, bus16.byte_count);
      hold16 = bus16.ks_valid && !(ena && (ks_ready || key_valid));
      last16 = bus16.ks_byte;
    end else hold16 = 1'b0;
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid0"}, 32'(bus0.ks_valid), 0);
    chk({tag, "_byte0"}, 32'(bus0.ks_byte), 0);
    chk({tag, "_busy0"}, 32'(bus0.busy), 0);
    chk({tag, "_cnt0"}, 32'(bus0.byte_count), 0);
    chk({tag, "_valid16"}, 32'(bus16.ks_valid), 0);
    chk({tag, "_byte16"}, 32'(bus16.ks_byte), 0);
    chk({tag, "_busy16"}, 32'(bus16.busy), 0);
    chk({tag, "_cnt16"}, 32'(bus16.byte_count), 0);
  endtask

  // mode: 0 ready always high, 1 random ready/ena, 2 ready 1,0,0,1 then high
  task automatic session(input logic [31:0] key, input int m, input int mode,
                         input bit gaps, input bit ena_gap);
    int lat;
    int cyc;
    bit busy_ok;
    for (int i = 0; i < 4; i++) begin
      if (gaps && i > 0) begin
        repeat ($urandom_range(0, 2)) begin
          key_valid = 1'b0;
          ks_ready  = 1'($urandom_range(0, 1));
          tick();
        end
      end
      key_valid = 1'b1;
      key_byte  = key[31-8*i -: 8];
      ks_ready  = 1'($urandom_range(0, 1));
      tick();
      if (i == 0) begin
        chk("rekey_valid0", 32'(bus0.ks_valid), 0);
        chk("rekey_valid16", 32'(bus16.ks_valid), 0);
        chk("rekey_cnt0", 32'(bus0.byte_count), prev_cnt);
        chk("rekey_cnt16", 32'(bus16.byte_count), prev_cnt);
        chk("busy16_load", 32'(bus16.busy), 1);
      end
    end
    key_valid = 1'b0;
    ks_ready  = 1'b0;
    chk("clr_cnt0", 32'(bus0.byte_count), 0);
    chk("clr_cnt16", 32'(bus16.byte_count), 0);
    chk("lat0_valid", 32'(bus0.ks_valid), 1);
    chk("busy0_run", 32'(bus0.busy), 0);
    push_expected(key, m);

    lat = 1;
    busy_ok = 1'b1;
    while (!bus16.ks_valid && lat < 100) begin
      if (!bus16.busy) busy_ok = 1'b0;
      if (ena_gap && lat == 3) ena = 1'b0;
      if (ena_gap && lat == 8) ena = 1'b1;
      tick();
      lat++;
    end
    ena = 1'b1;
    chk("lat16", 32'(lat), ena_gap ? 22 : 17);
    chk("busy16_warm", 32'(busy_ok), 1);
    chk("busy16_run", 32'(bus16.busy), 0);

    cyc = 0;
    while (q16.size() != 0 && cyc < 3000) begin
      case (mode)
        0: begin ks_ready = 1'b1; ena = 1'b1; end
        2: begin
          ks_ready = (cyc >= 4) || (cyc == 0) || (cyc == 3);
          ena = 1'b1;
        end
        default: begin
          ks_ready = 1'($urandom_range(0, 1));
          ena = ($urandom_range(0, 7) != 0);
        end
      endcase
      tick();
      cyc++;
    end
    ks_ready = 1'b0;
    ena = 1'b1;
    chk("drain16", 32'(q16.size()), 0);
    chk("drain0", 32'(q0.size()), 0);
    chk("cnt_end0", 32'(bus0.byte_count), m);
    chk("cnt_end16", 32'(bus16.byte_count), m);
    prev_cnt = m;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    ena = 1'b1;
    tick();

    session(32'h1234_5678, 4, 0, 1'b0, 1'b0);
    session(32'h0000_0000, 8, 1, 1'b0, 1'b0);
    session($urandom, 4, 2, 1'b0, 1'b0);
    session($urandom, 6, 1, 1'b1, 1'b1);
    for (int s = 0; s < 6; s++) session($urandom, $urandom_range(3, 12), 1, 1'b1, 1'b0);

    key_valid = 1'b1;
    key_byte  = 8'hAA;
    tick();
    key_byte  = 8'hBB;
    tick();
    rst_n = 1'b0;
    key_valid = 1'b0;
    #1;
    check_reset_outputs("midload_rst");
    tick();
    rst_n = 1'b1;
    tick();
    prev_cnt = 0;
    session(32'hA1B2_C3D4, 3, 1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
